// File: rtl/nibble_frame_rx.sv
// Receiver for a framed nibble stream: finds the two-nibble sync word, packs the data nibbles
// into bytes (high nibble first), checks a trailing XOR checksum and counts good/bad frames.
module nibble_frame_rx #(
  parameter int unsigned FRAME_BYTES = 4,
  parameter logic [3:0]  SYNC_HI     = 4'hA,
  parameter logic [3:0]  SYNC_LO     = 4'h5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] Din,
  input  logic       Din_En,
  output logic [7:0] Byte_Data,
  output logic       Byte_Valid,
  output logic       Frame_Done,
  output logic       Frame_Err,
  output logic [7:0] Good_Cnt,
  output logic [7:0] Err_Cnt
);

  localparam int unsigned NumNibbles = 2 * FRAME_BYTES;
  localparam int unsigned IdxW       = (NumNibbles > 2) ? $clog2(NumNibbles) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumNibbles - 1);

  typedef enum logic [1:0] {StIdle, StSync, StData, StCheck} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [3:0]      csum_q, csum_d;
  logic [3:0]      hi_q, hi_d;
  logic [7:0]      byte_data_q, byte_data_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_done_q, frame_done_d;
  logic            frame_err_q, frame_err_d;
  logic [7:0]      good_cnt_q, good_cnt_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    csum_d       = csum_q;
    hi_d         = hi_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    good_cnt_d   = good_cnt_q;
    err_cnt_d    = err_cnt_q;

    if (Din_En) begin
      unique case (state_q)
        StIdle: begin
          if (Din == SYNC_HI) state_d = StSync;
        end
        StSync: begin
          if (Din == SYNC_LO) begin
            state_d = StData;
            idx_d   = '0;
            csum_d  = '0;
          end else if (Din != SYNC_HI) begin
            state_d = StIdle;
          end
        end
        StData: begin
          // Sync values are ordinary data here; only the nibble index matters.
          csum_d = csum_q ^ Din;
          idx_d  = idx_q + 1'b1;
          if (!idx_q[0]) begin
            hi_d = Din;
          end else begin
            byte_data_d  = {hi_q, Din};
            byte_valid_d = 1'b1;
          end
          if (idx_q == LastIdx) state_d = StCheck;
        end
        StCheck: begin
          frame_done_d = 1'b1;
          if (Din != csum_q) begin
            frame_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end else begin
            good_cnt_d = good_cnt_q + 8'd1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      csum_q       <= '0;
      hi_q         <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      good_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      hi_q         <= hi_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      good_cnt_q   <= good_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign Byte_Data  = byte_data_q;
  assign Byte_Valid = byte_valid_q;
  assign Frame_Done = frame_done_q;
  assign Frame_Err  = frame_err_q;
  assign Good_Cnt   = good_cnt_q;
  assign Err_Cnt    = err_cnt_q;

endmodule

// File: tb/tb_nibble_frame_rx.sv
// Bench for nibble_frame_rx: fixed vector table, hand-written corner sequences and random
// framed traffic, all checked against a frame-level reference model.
module tb_nibble_frame_rx;

  localparam int unsigned FB = 4;
  localparam logic [3:0] SH = 4'hA;
  localparam logic [3:0] SL = 4'h5;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] Din = 4'h0;
  logic       Din_En = 1'b0;
  logic [7:0] Byte_Data;
  logic       Byte_Valid;
  logic       Frame_Done;
  logic       Frame_Err;
  logic [7:0] Good_Cnt;
  logic [7:0] Err_Cnt;

  nibble_frame_rx #(.FRAME_BYTES(FB), .SYNC_HI(SH), .SYNC_LO(SL)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Din       (Din),
    .Din_En    (Din_En),
    .Byte_Data (Byte_Data),
    .Byte_Valid(Byte_Valid),
    .Frame_Done(Frame_Done),
    .Frame_Err (Frame_Err),
    .Good_Cnt  (Good_Cnt),
    .Err_Cnt   (Err_Cnt)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is the list of data nibbles collected after a sync word.
  logic [3:0] m_data[$];
  bit         m_in_frame = 0;
  bit         m_prev_hi = 0;
  logic       m_bv = 0, m_fd = 0, m_fe = 0;
  logic [7:0] m_bd = 0;
  int         m_good = 0, m_err = 0;

  task automatic model_step(input logic r, input logic e, input logic [3:0] d);
    logic [3:0] x;
    m_bv = 0; m_fd = 0; m_fe = 0;
    if (r) begin
      m_data.delete(); m_in_frame = 0; m_prev_hi = 0;
      m_bd = 0; m_good = 0; m_err = 0;
    end else if (e) begin
      if (!m_in_frame) begin
        if (m_prev_hi && d == SL) begin
          m_in_frame = 1;
          m_data.delete();
          m_prev_hi = 0;
        end else begin
          m_prev_hi = (d == SH);
        end
      end else if (m_data.size() < 2 * FB) begin
        m_data.push_back(d);
        if (m_data.size() % 2 == 0) begin
          m_bv = 1;
          m_bd = {m_data[m_data.size()-2], m_data[m_data.size()-1]};
        end
      end else begin
        x = 4'h0;
        foreach (m_data[i]) x ^= m_data[i];
        m_fd = 1;
        if (x == d) m_good = (m_good + 1) % 256;
        else begin
          m_fe = 1;
          if (m_err < 255) m_err++;
        end
        m_in_frame = 0;
        m_prev_hi = 0;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic [3:0] d);
    RST = r; Din_En = e; Din = d;
    @(posedge CLK);
    model_step(r, e, d);
    #1;
    chk("model Byte_Valid", {31'd0, Byte_Valid}, {31'd0, m_bv});
    chk("model Byte_Data", {24'd0, Byte_Data}, {24'd0, m_bd});
    chk("model Frame_Done", {31'd0, Frame_Done}, {31'd0, m_fd});
    chk("model Frame_Err", {31'd0, Frame_Err}, {31'd0, m_fe});
    chk("model Good_Cnt", {24'd0, Good_Cnt}, m_good);
    chk("model Err_Cnt", {24'd0, Err_Cnt}, m_err);
  endtask

  // Sends seq_q, with a Din_En=0 cycle (random Din) after each nibble with probability gap_pct%.
  logic [3:0] seq_q[$];
  task automatic send_seq(input int gap_pct);
    foreach (seq_q[i]) begin
      cyc(1'b0, 1'b1, seq_q[i]);
      if ($urandom_range(99) < gap_pct) cyc(1'b0, 1'b0, 4'($urandom));
    end
    seq_q.delete();
  endtask

  task automatic push_frame(input bit good, input bit rand_data);
    logic [3:0] x, n;
    x = 4'h0;
    seq_q.push_back(SH);
    seq_q.push_back(SL);
    for (int i = 0; i < 2 * FB; i++) begin
      n = rand_data ? 4'($urandom) : 4'(i + 1);
      x ^= n;
      seq_q.push_back(n);
    end
    seq_q.push_back(good ? x : x ^ 4'($urandom_range(1, 15)));
  endtask

  typedef struct {
    logic       rst, en;
    logic [3:0] din;
    logic       bv;
    logic [7:0] bd;
    logic       fd, fe;
    logic [7:0] good, err;
  } vec_t;
  vec_t vecs[$];

  // Rows for the frame A,5,1..8,csum; data 1..8 XOR to 8.
  task automatic add_frame_rows(input logic [3:0] csum, input bit gaps,
                                input logic [7:0] g0, input logic [7:0] e0);
    logic [3:0] nib[11];
    vec_t v;
    nib[0] = SH; nib[1] = SL;
    for (int i = 0; i < 8; i++) nib[i+2] = 4'(i + 1);
    nib[10] = csum;
    for (int i = 0; i < 11; i++) begin
      v.rst = 0; v.en = 1; v.din = nib[i];
      v.bv = (i >= 3 && i <= 9 && i % 2 == 1);
      v.bd = v.bv ? {nib[i-1], nib[i]} : 8'h00;
      v.fd = (i == 10);
      v.fe = (i == 10) && (csum != 4'h8);
      v.good = (i == 10 && csum == 4'h8) ? g0 + 8'd1 : g0;
      v.err = (i == 10 && csum != 4'h8) ? e0 + 8'd1 : e0;
      vecs.push_back(v);
      if (gaps) begin
        v.en = 0; v.din = 4'hF; v.bv = 0; v.fd = 0; v.fe = 0;
        vecs.push_back(v);
      end
    end
  endtask

  int g_snap, e_snap;

  initial begin
    vec_t v;
    // Reset held 3 cycles with a sync nibble on the bus.
    for (int i = 0; i < 3; i++) begin
      v = '{rst: 1, en: 1, din: SH, bv: 0, bd: 0, fd: 0, fe: 0, good: 0, err: 0};
      vecs.push_back(v);
    end
    add_frame_rows(4'h8, 1'b0, 8'd0, 8'd0);
    add_frame_rows(4'h0, 1'b0, 8'd1, 8'd0);
    add_frame_rows(4'h8, 1'b1, 8'd1, 8'd1);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].en, vecs[i].din);
      chk($sformatf("vec%0d Byte_Valid", i), {31'd0, Byte_Valid}, {31'd0, vecs[i].bv});
      if (vecs[i].bv) chk($sformatf("vec%0d Byte_Data", i), {24'd0, Byte_Data}, {24'd0, vecs[i].bd});
      chk($sformatf("vec%0d Frame_Done", i), {31'd0, Frame_Done}, {31'd0, vecs[i].fd});
      chk($sformatf("vec%0d Frame_Err", i), {31'd0, Frame_Err}, {31'd0, vecs[i].fe});
      chk($sformatf("vec%0d Good_Cnt", i), {24'd0, Good_Cnt}, {24'd0, vecs[i].good});
      chk($sformatf("vec%0d Err_Cnt", i), {24'd0, Err_Cnt}, {24'd0, vecs[i].err});
    end

    // A,A,5 still syncs.
    seq_q.push_back(SH);
    push_frame(1'b1, 1'b0);
    send_seq(0);
    chk("double sync Good_Cnt", {24'd0, Good_Cnt}, 32'd3);

    // A,3,5 does not sync; trailing nibbles contain no sync word.
    seq_q = '{SH, 4'h3, SL, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9, 4'h8};
    send_seq(0);
    chk("broken sync Good_Cnt", {24'd0, Good_Cnt}, 32'd3);
    chk("broken sync Err_Cnt", {24'd0, Err_Cnt}, 32'd1);

    // Sync values as data give byte A5, no resync; XOR of four A,5 pairs is 0.
    seq_q = '{SH, SL, SH, SL, SH, SL, SH, SL, SH, SL, 4'h0};
    send_seq(0);
    chk("sync-as-data Good_Cnt", {24'd0, Good_Cnt}, 32'd4);
    chk("sync-as-data Byte_Data", {24'd0, Byte_Data}, 32'hA5);

    // 256 back-to-back good frames wrap Good_Cnt.
    cyc(1'b1, 1'b0, 4'h0);
    for (int f = 0; f < 256; f++) push_frame(1'b1, 1'b1);
    send_seq(0);
    chk("wrap Good_Cnt", {24'd0, Good_Cnt}, 32'd0);

    // 260 bad frames saturate Err_Cnt.
    for (int f = 0; f < 260; f++) push_frame(1'b0, 1'b1);
    send_seq(0);
    chk("saturate Err_Cnt", {24'd0, Err_Cnt}, 32'd255);
    chk("saturate Good_Cnt", {24'd0, Good_Cnt}, 32'd0);

    // Reset after the third data nibble abandons the frame.
    seq_q = '{SH, SL, 4'h1, 4'h2, 4'h3};
    send_seq(0);
    cyc(1'b1, 1'b1, 4'h4);
    chk("midreset Byte_Valid", {31'd0, Byte_Valid}, 32'd0);
    chk("midreset Byte_Data", {24'd0, Byte_Data}, 32'd0);
    chk("midreset Good_Cnt", {24'd0, Good_Cnt}, 32'd0);
    chk("midreset Err_Cnt", {24'd0, Err_Cnt}, 32'd0);
    push_frame(1'b1, 1'b0);
    send_seq(0);
    chk("post-reset Good_Cnt", {24'd0, Good_Cnt}, 32'd1);
    chk("post-reset Byte_Data", {24'd0, Byte_Data}, 32'h78);

    // Random frames, junk and gaps; the per-cycle model checks do the work.
    for (int it = 0; it < 300; it++) begin
      g_snap = $urandom_range(99);
      if (g_snap < 70) push_frame($urandom_range(1), 1'b1);
      else for (int k = 0; k < $urandom_range(1, 6); k++) seq_q.push_back(4'($urandom));
      send_seq(25);
      if ($urandom_range(199) == 0) cyc(1'b1, 1'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
